game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Match clock for the game. Counts the remaining match time down in whole seconds.
- Feeds the 3-digit on-screen timer/score display with the 8-bit binary time value and the `playing_reg` flag. The display shows the value while `playing_reg`=1 and shows "000" otherwise.
- Also reports game-over and low-time status to the game control logic.

Parameters:
- TICK_DIV, 25_000_000: clk cycles per one-second tick (25 MHz pixel clock). Benches override this with a small value.
- START_TIME, 120: seconds loaded when a match starts. Range 1..MAX_TIME.
- BONUS_TIME, 10: seconds added on each `bonus` pulse.
- MAX_TIME, 199: saturation ceiling for the time value. Must be ≤255 and fit 3 BCD digits.
- LOW_THRESH, 10: `time_low` asserts while time_value ≤ this value.

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  synchronous, active-high reset
- start_btn  in  1  debounced start button, level
- pause_btn  in  1  debounced pause button, level
- bonus  in  1  one-cycle pulse from game logic (snitch caught)
- time_value  out  8  remaining seconds, binary, to display `score` input
- playing_reg  out  1  high in RUN and PAUSE states, to display
- game_over  out  1  one-cycle pulse when time expires
- time_low  out  1  high in RUN/PAUSE when 0 < time_value ≤ LOW_THRESH
- sec_tick  out  1  one-cycle pulse on each counted second (RUN only)

Behaviour:
- All registers update on the rising edge of clk. The reset is synchronous, active-high, and has priority over every other input.
- Reset values:
  - state = IDLE
  - time_value = 0
  - playing_reg = 0, game_over = 0, time_low = 0, sec_tick = 0
  - prescaler = 0
  - edge-detect history registers = 0
- Button edges:
  - start_btn and pause_btn are each registered once.
  - A rise is detected when the current value is 1 and the registered value is 0.
  - Holding a button produces exactly one event.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. On reaching TICK_DIV-1 it wraps to 0 and generates a tick. It holds in PAUSE and clears to 0 in all other states and on entry to RUN.
- States:
  - IDLE: time_value = 0.
    - start rise → RUN; load time_value = START_TIME; clear prescaler.
  - RUN: on tick, sec_tick = 1 in that same cycle and time_value decrements.
    - Decrement to 0 → OVER; game_over = 1 for exactly that cycle.
    - pause rise → PAUSE.
    - start rise is ignored.
  - PAUSE: time_value and prescaler frozen. `bonus` is ignored.
    - pause rise → RUN; prescaler resumes from its held value.
  - OVER: time_value = 0; playing_reg = 0.
    - start rise → IDLE.
    - A start rise is needed again from IDLE to begin a new match. This requires two presses and prevents an accidental restart.
- Outputs are registered: playing_reg = 1 in the same cycle state = RUN or PAUSE.
- Bonus (RUN only):
  - new = min(time_value + BONUS_TIME, MAX_TIME).
  - Compute in 9 bits before saturating.
- Simultaneous tick and bonus in RUN:
  - new = min(time_value − 1 + BONUS_TIME, MAX_TIME).
  - No game_over, even if time_value was 1.
- Simultaneous pause rise and tick in RUN: the tick is applied (decrement/OVER takes effect) and the pause is then honoured.
  - If the tick expires the time, the state goes to OVER and the pause is dropped.
- time_low is derived from the registered state and time_value: it is 0 in IDLE/OVER and 0 when time_value = 0.
- Reset mid-match: the next cycle shows IDLE and all outputs at their reset values, regardless of state.

Test Plan:
1. TICK_DIV=4, START_TIME=3. Reset, then a start_btn rise → playing_reg=1 and time_value=3 in the next cycle. sec_tick every 4 cycles; values 2,1,0. game_over is a single-cycle pulse coinciding with time_value=0, then state OVER with playing_reg=0.
2. Hold start_btn high for 20 cycles → a single match start; time_value is not reloaded. In OVER, one start rise → IDLE and time_value stays 0. A second rise → RUN with time_value=3.
3. RUN at time_value=195, MAX_TIME=199, BONUS_TIME=10 → bonus gives 199. A further bonus stays at 199. bonus during PAUSE → no change.
4. time_value=1 with bonus asserted on the tick cycle → time_value=10, no game_over, state remains RUN.
5. Pause rise at prescaler=2, wait 50 cycles → time_value unchanged and sec_tick=0. Pause rise again → next tick arrives 2 cycles later (prescaler resumed). time_low=1 throughout when time_value ≤10.
6. Assert reset in PAUSE with time_value=7 → next cycle: time_value=0, playing_reg=0, time_low=0, game_over=0, state IDLE.

Source files
------------

// File: rtl/game_countdown_timer.sv
`default_nettype none
// game_countdown_timer: whole-second match clock with pause, bonus time,
// low-time flag and a game-over pulse for the on-screen timer display.
module game_countdown_timer #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int START_TIME = 120,
  parameter int BONUS_TIME = 10,
  parameter int MAX_TIME   = 199,
  parameter int LOW_THRESH = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       bonus,
  output logic [7:0] time_value,
  output logic       playing_reg,
  output logic       game_over,
  output logic       time_low,
  output logic       sec_tick
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [7:0]    START_V8   = 8'(START_TIME);
  localparam logic [8:0]    BONUS_V    = 9'(BONUS_TIME);
  localparam logic [8:0]    MAX_V      = 9'(MAX_TIME);
  localparam logic [7:0]    MAX_V8     = 8'(MAX_TIME);
  localparam logic [8:0]    LOW_V      = 9'(LOW_THRESH);
  localparam logic          START_LOW  = (START_TIME > 0) && (START_TIME <= LOW_THRESH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          start_q;
  logic          pause_q;

  logic          start_rise;
  logic          pause_rise;
  logic          tick;
  logic          expire;
  logic          run_low;
  logic [8:0]    base;
  logic [8:0]    bonus_sum;
  logic [7:0]    bonus_sat;
  logic [7:0]    run_next;

  assign start_rise = start_btn & ~start_q;
  assign pause_rise = pause_btn & ~pause_q;
  assign tick       = (state == RUN) && (presc == PRESC_LAST);

  // A tick and a bonus in the same cycle combine; the 9-bit sum avoids wrap before saturation.
  assign base       = {1'b0, time_value} - {8'd0, tick};
  assign bonus_sum  = base + BONUS_V;
  assign bonus_sat  = (bonus_sum > MAX_V) ? MAX_V8 : bonus_sum[7:0];
  assign run_next   = bonus ? bonus_sat : base[7:0];
  assign expire     = tick && !bonus && (time_value == 8'd1);
  assign run_low    = (run_next != 8'd0) && ({1'b0, run_next} <= LOW_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      time_value  <= '0;
      playing_reg <= 1'b0;
      game_over   <= 1'b0;
      time_low    <= 1'b0;
      sec_tick    <= 1'b0;
      presc       <= '0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      start_q   <= start_btn;
      pause_q   <= pause_btn;
      game_over <= 1'b0;
      sec_tick  <= tick;

      case (state)
        IDLE: begin
          presc <= '0;
          if (start_rise) begin
            state       <= RUN;
            time_value  <= START_V8;
            playing_reg <= 1'b1;
            time_low    <= START_LOW;
          end else begin
            time_value  <= '0;
            playing_reg <= 1'b0;
            time_low    <= 1'b0;
          end
        end

        RUN: begin
          // The pause-rise cycle does not advance the prescaler, so the held
          // count is exactly the progress made into the current second.
          if (tick) begin
            presc <= '0;
          end else if (!pause_rise) begin
            presc <= presc + PRESC_ONE;
          end

          if (expire) begin
            state       <= OVER;
            time_value  <= '0;
            playing_reg <= 1'b0;
            time_low    <= 1'b0;
            game_over   <= 1'b1;
          end else begin
            state       <= pause_rise ? PAUSE : RUN;
            time_value  <= run_next;
            playing_reg <= 1'b1;
            time_low    <= run_low;
          end
        end

        PAUSE: begin
          playing_reg <= 1'b1;
          if (pause_rise) begin
            state <= RUN;
          end
        end

        OVER: begin
          presc       <= '0;
          time_value  <= '0;
          playing_reg <= 1'b0;
          time_low    <= 1'b0;
          if (start_rise) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_countdown_timer.sv
`default_nettype none
// Directed bench for game_countdown_timer: instance a runs a short 3-second
// match, instance b starts near the saturation ceiling; both share stimulus.
module tb_game_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       pause_btn;
  logic       bonus;

  logic [7:0] tv_a;
  logic       play_a;
  logic       over_a;
  logic       low_a;
  logic       tick_a;
  logic [7:0] tv_b;
  logic       play_b;
  logic       over_b;
  logic       low_b;
  logic       tick_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_countdown_timer #(
    .TICK_DIV(4), .START_TIME(3), .BONUS_TIME(10), .MAX_TIME(199), .LOW_THRESH(10)
  ) dut_a (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn), .bonus(bonus),
    .time_value(tv_a), .playing_reg(play_a), .game_over(over_a), .time_low(low_a),
    .sec_tick(tick_a)
  );

  game_countdown_timer #(
    .TICK_DIV(64), .START_TIME(195), .BONUS_TIME(10), .MAX_TIME(199), .LOW_THRESH(10)
  ) dut_b (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn), .bonus(bonus),
    .time_value(tv_b), .playing_reg(play_b), .game_over(over_b), .time_low(low_b),
    .sec_tick(tick_b)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen_tick;
    reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; bonus = 1'b0;
    cyc(2);
    chk("rst_time", tv_a, 0);
    chk("rst_play", play_a, 0);
    chk("rst_over", over_a, 0);
    chk("rst_low", low_a, 0);
    chk("rst_tick", tick_a, 0);
    chk("rst_time_b", tv_b, 0);
    reset = 1'b0;

    // Basic countdown 3,2,1,0 with one tick per 4 cycles
    start_btn = 1'b1; cyc(1);
    chk("t1_start_time", tv_a, 3);
    chk("t1_start_play", play_a, 1);
    chk("t1_start_low", low_a, 1);
    start_btn = 1'b0; cyc(3);
    chk("t1_e4_time", tv_a, 3);
    chk("t1_e4_tick", tick_a, 0);
    cyc(1);
    chk("t1_e5_time", tv_a, 2);
    chk("t1_e5_tick", tick_a, 1);
    cyc(1);
    chk("t1_e6_tick", tick_a, 0);
    cyc(3);
    chk("t1_e9_time", tv_a, 1);
    chk("t1_e9_tick", tick_a, 1);
    cyc(4);
    chk("t1_e13_time", tv_a, 0);
    chk("t1_e13_over", over_a, 1);
    chk("t1_e13_play", play_a, 0);
    chk("t1_e13_low", low_a, 0);
    cyc(1);
    chk("t1_e14_over", over_a, 0);
    chk("t1_e14_play", play_a, 0);

    // Held start gives one match; OVER needs two presses to restart
    reset = 1'b1; cyc(1); reset = 1'b0;
    start_btn = 1'b1; cyc(1);
    chk("t2_start_time", tv_a, 3);
    cyc(11);
    chk("t2_noreload_time", tv_a, 1);
    chk("t2_noreload_play", play_a, 1);
    cyc(8);
    chk("t2_held_over_time", tv_a, 0);
    chk("t2_held_over_play", play_a, 0);
    start_btn = 1'b0; cyc(1);
    start_btn = 1'b1; cyc(1);
    chk("t2_to_idle_time", tv_a, 0);
    chk("t2_to_idle_play", play_a, 0);
    start_btn = 1'b0; cyc(1);
    start_btn = 1'b1; cyc(1);
    chk("t2_restart_time", tv_a, 3);
    chk("t2_restart_play", play_a, 1);
    start_btn = 1'b0;

    // Bonus adds and saturates; pause freezes time and prescaler
    reset = 1'b1; cyc(1); reset = 1'b0;
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    chk("t3_b_start", tv_b, 195);
    bonus = 1'b1; cyc(1);
    chk("t3_b_sat", tv_b, 199);
    chk("t3_a_bonus1", tv_a, 13);
    cyc(1);
    chk("t3_b_sat_again", tv_b, 199);
    chk("t3_a_bonus2", tv_a, 23);
    bonus = 1'b0; pause_btn = 1'b1; cyc(1);
    pause_btn = 1'b0; bonus = 1'b1; cyc(1);
    bonus = 1'b0;
    chk("t3_pause_bonus_a", tv_a, 23);
    chk("t3_pause_bonus_b", tv_b, 199);
    chk("t3_pause_play", play_a, 1);
    chk("t3_pause_low", low_a, 0);
    seen_tick = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (tick_a !== 1'b0) seen_tick = 1'b1;
    end
    chk("t5_pause_no_tick", seen_tick, 0);
    chk("t5_pause_time", tv_a, 23);
    pause_btn = 1'b1; cyc(1); pause_btn = 1'b0;
    chk("t5_resume_play", play_a, 1);
    cyc(1);
    chk("t5_resume_r1_tick", tick_a, 0);
    chk("t5_resume_r1_time", tv_a, 23);
    cyc(1);
    chk("t5_resume_r2_tick", tick_a, 1);
    chk("t5_resume_r2_time", tv_a, 22);

    // Bonus on the tick that would expire the match
    reset = 1'b1; cyc(1); reset = 1'b0;
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    cyc(11);
    chk("t4_pre_time", tv_a, 1);
    bonus = 1'b1; cyc(1); bonus = 1'b0;
    chk("t4_time", tv_a, 10);
    chk("t4_tick", tick_a, 1);
    chk("t4_over", over_a, 0);
    chk("t4_play", play_a, 1);
    chk("t4_low_at_thresh", low_a, 1);
    cyc(1);
    chk("t4_after_time", tv_a, 10);
    chk("t4_after_over", over_a, 0);
    bonus = 1'b1; cyc(1); bonus = 1'b0;
    chk("t4_bonus20_time", tv_a, 20);
    chk("t4_bonus20_low", low_a, 0);

    // Low threshold boundary, then reset while paused at 7
    reset = 1'b1; cyc(1); reset = 1'b0;
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    bonus = 1'b1; cyc(1); bonus = 1'b0;
    chk("t6_bonus_time", tv_a, 13);
    cyc(10);
    chk("t6_e12_time", tv_a, 11);
    chk("t6_e12_low", low_a, 0);
    cyc(1);
    chk("t6_e13_time", tv_a, 10);
    chk("t6_e13_low", low_a, 1);
    cyc(12);
    chk("t6_e25_time", tv_a, 7);
    pause_btn = 1'b1; cyc(1); pause_btn = 1'b0;
    cyc(3);
    chk("t6_paused_time", tv_a, 7);
    chk("t6_paused_play", play_a, 1);
    chk("t6_paused_low", low_a, 1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("t6_rst_time", tv_a, 0);
    chk("t6_rst_play", play_a, 0);
    chk("t6_rst_low", low_a, 0);
    chk("t6_rst_over", over_a, 0);
    chk("t6_rst_tick", tick_a, 0);

    // Pause rise on a tick cycle: tick applied, then paused
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
    chk("t7_start_time", tv_a, 3);
    cyc(3);
    pause_btn = 1'b1; cyc(1); pause_btn = 1'b0;
    chk("t7_tick_time", tv_a, 2);
    chk("t7_tick_flag", tick_a, 1);
    cyc(5);
    chk("t7_paused_time", tv_a, 2);
    chk("t7_paused_play", play_a, 1);
    chk("t7_paused_tick", tick_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
